// File: rtl/pipe_mon_pkg.sv
// pipe_mon_pkg: shared types for the pipeline stage-enable monitor.
//   phase_e    - decoded pipeline phase (IDLE/FILL/RUN/DRAIN)
//   class_e    - class of one stage-enable code (ZERO/FILL/FULL/DRAIN/ILLEGAL)
//   ERR_*      - err_code values (first cause wins)
//   code_class - classify an n-bit vector (n <= MAX_W), upper bits ignored
package pipe_mon_pkg;

  typedef enum logic [1:0] {PH_IDLE, PH_FILL, PH_RUN, PH_DRAIN} phase_e;
  typedef enum logic [2:0] {CL_ZERO, CL_FILL, CL_FULL, CL_DRAIN, CL_ILL} class_e;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_CODE = 2'b01;
  localparam logic [1:0] ERR_STEP = 2'b10;

  localparam int MAX_W = 32;
  localparam logic [MAX_W-1:0] ONE = 1;

  function automatic class_e code_class(input logic [MAX_W-1:0] vec, input int n);
    logic [MAX_W-1:0] mask, v, inv;
    for (int i = 0; i < MAX_W; i++) mask[i] = (i < n);
    v   = vec & mask;
    inv = ~vec & mask;
    if (v == '0)                return CL_ZERO;
    if (inv == '0)              return CL_FULL;
    // contiguous ones from bit 0 upward: adding one clears them all
    if ((v & (v + ONE)) == '0)  return CL_FILL;
    // contiguous zeros from bit 0 upward means the ones sit at the top
    if ((inv & (inv + ONE)) == '0) return CL_DRAIN;
    return CL_ILL;
  endfunction

endpackage

// File: rtl/pipe_code_classify.sv
// pipe_code_classify: combinational classifier of one stage-enable code.
//   vec  in  NSTAGE        stage-enable vector
//   cls  out class_e       ZERO/FILL/FULL/DRAIN/ILLEGAL
//   idx  out clog2(N+1)    number of set bits (k of FILLk, j of DRAINj)
module pipe_code_classify
  import pipe_mon_pkg::*;
#(
  parameter int NSTAGE = 4
) (
  input  logic [NSTAGE-1:0]             vec,
  output class_e                        cls,
  output logic [$clog2(NSTAGE+1)-1:0]   idx
);
  localparam int IDX_W = $clog2(NSTAGE+1);

  logic [MAX_W-1:0] ext;

  always_comb begin
    ext = '0;
    ext[NSTAGE-1:0] = vec;
    cls = code_class(ext, NSTAGE);
    idx = IDX_W'($countones(vec));
  end

endmodule

// File: rtl/pipe_stage_monitor.sv
// pipe_stage_monitor: consumer-side monitor of the pipeline stage-enable sequence
// (fill 0..01 -> 1..1, hold, drain 1..10 -> 0). Every output is registered and
// reflects the stg_en sampled at the previous CLK edge.
//   CLK, RSTN            clock / async active-low reset (release synchronised)
//   stg_en [NSTAGE]      stage-enable vector, sampled every edge
//   clr                  sync clear of run_cycles, err, err_code
//   busy/filling/running/draining   decoded phase flags
//   fill_done/drain_done 1-cycle completion pulses
//   run_cycles [CNT_W]   saturating count of FULL samples in current/last run
//   err, err_code [2]    sticky first error (01 illegal code, 10 illegal step)
// Build option: define PIPE_MON_CHECK_EN to enable code/step checking; without it
// err/err_code are tied to 0 and pulses follow the class transitions alone.
module pipe_stage_monitor
  import pipe_mon_pkg::*;
#(
  parameter int NSTAGE = 4,
  parameter int CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic [NSTAGE-1:0] stg_en,
  input  logic              clr,
  output logic              busy,
  output logic              filling,
  output logic              running,
  output logic              draining,
  output logic              fill_done,
  output logic              drain_done,
  output logic [CNT_W-1:0]  run_cycles,
  output logic              err,
  output logic [1:0]        err_code
);
  localparam int IDX_W = $clog2(NSTAGE+1);

  // assert immediately, release two edges later so no flop sees a ragged release
  logic [1:0] rst_sync;
  logic       rst_n;
  always_ff @(posedge CLK or negedge RSTN)
    if (!RSTN) rst_sync <= '0;
    else       rst_sync <= {rst_sync[0], 1'b1};
  assign rst_n = rst_sync[1];

  logic [NSTAGE-1:0] prev_vec;
  class_e            cur_cls, prev_cls;
  logic [IDX_W-1:0]  cur_idx, prev_idx;

  pipe_code_classify #(.NSTAGE(NSTAGE)) u_cur  (.vec(stg_en),   .cls(cur_cls),  .idx(cur_idx));
  pipe_code_classify #(.NSTAGE(NSTAGE)) u_prev (.vec(prev_vec), .cls(prev_cls), .idx(prev_idx));

  logic       new_err, pulse_ok;
  logic [1:0] new_code;

`ifdef PIPE_MON_CHECK_EN
  logic step_ok, code_bad;
  always_comb begin
    step_ok = 1'b0;
    case (prev_cls)
      CL_ZERO:  step_ok = (cur_cls == CL_ZERO) || (cur_cls == CL_FILL && cur_idx == IDX_W'(1));
      CL_FILL:  step_ok = (prev_idx == IDX_W'(NSTAGE-1)) ? (cur_cls == CL_FULL)
                        : (cur_cls == CL_FILL && cur_idx == prev_idx + IDX_W'(1));
      CL_FULL:  step_ok = (cur_cls == CL_FULL) || (cur_cls == CL_DRAIN && cur_idx == IDX_W'(NSTAGE-1));
      CL_DRAIN: step_ok = (prev_idx == IDX_W'(1)) ? (cur_cls == CL_ZERO)
                        : (cur_cls == CL_DRAIN && cur_idx == prev_idx - IDX_W'(1));
      default:  step_ok = 1'b0;  // nothing legally follows an illegal code
    endcase
  end
  assign code_bad = (cur_cls == CL_ILL);
  assign new_err  = code_bad || !step_ok;
  assign new_code = code_bad ? ERR_CODE : ERR_STEP;
  assign pulse_ok = step_ok;
`else
  logic unused_prev_idx;
  assign unused_prev_idx = ^prev_idx;
  assign new_err  = 1'b0;
  assign new_code = ERR_NONE;
  assign pulse_ok = 1'b1;
`endif

  // phase FSM: register / next-state / outputs
  phase_e phase, phase_nxt;

  always_ff @(posedge CLK or negedge rst_n)
    if (!rst_n) phase <= PH_IDLE;
    else        phase <= phase_nxt;

  always_comb begin
    phase_nxt = PH_IDLE;  // ZERO and ILLEGAL both resync to IDLE
    case (cur_cls)
      CL_FILL:  phase_nxt = PH_FILL;
      CL_FULL:  phase_nxt = PH_RUN;
      CL_DRAIN: phase_nxt = PH_DRAIN;
      default:  phase_nxt = PH_IDLE;
    endcase
  end

  always_comb begin
    busy     = (phase != PH_IDLE);
    filling  = (phase == PH_FILL);
    running  = (phase == PH_RUN);
    draining = (phase == PH_DRAIN);
  end

  logic             new_run;
  logic [CNT_W-1:0] rc_base;
  assign new_run = (prev_cls == CL_ZERO) && (cur_cls == CL_FILL) && (cur_idx == IDX_W'(1));
  assign rc_base = (clr || new_run) ? '0 : run_cycles;

  always_ff @(posedge CLK or negedge rst_n)
    if (!rst_n) begin
      prev_vec   <= '0;
      fill_done  <= 1'b0;
      drain_done <= 1'b0;
      run_cycles <= '0;
      err        <= 1'b0;
      err_code   <= ERR_NONE;
    end else begin
      prev_vec   <= stg_en;
      fill_done  <= pulse_ok && (prev_cls != CL_FULL) && (cur_cls == CL_FULL);
      drain_done <= pulse_ok && (prev_cls == CL_DRAIN || prev_cls == CL_FULL) && (cur_cls == CL_ZERO);
      if (cur_cls == CL_FULL)
        run_cycles <= (rc_base == '1) ? rc_base : rc_base + CNT_W'(1);
      else
        run_cycles <= rc_base;
      // a new error in the clr cycle is latched as the first error after the clear
      if (clr) begin
        err      <= new_err;
        err_code <= new_err ? new_code : ERR_NONE;
      end else if (new_err && !err) begin
        err      <= 1'b1;
        err_code <= new_code;
      end
    end

endmodule

// File: tb/tb_pipe_stage_monitor.sv
// tb_pipe_stage_monitor: directed self-checking bench for pipe_stage_monitor
// (NSTAGE=4, CNT_W=4). Expectations for err/err_code and for the pulses on an
// illegal step follow whether PIPE_MON_CHECK_EN is defined for the build.
module tb_pipe_stage_monitor;

`ifdef PIPE_MON_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  // phase flag groups: {busy, filling, running, draining}
  localparam logic [3:0] IDLE  = 4'b0000;
  localparam logic [3:0] FILL  = 4'b1100;
  localparam logic [3:0] RUN   = 4'b1010;
  localparam logic [3:0] DRAIN = 4'b1001;

  logic       CLK = 1'b0;
  logic       RSTN = 1'b0;
  logic [3:0] stg_en = 4'h0;
  logic       clr = 1'b0;
  logic       busy, filling, running, draining, fill_done, drain_done, err;
  logic [3:0] run_cycles;
  logic [1:0] err_code;

  int n_tests = 0;
  int n_fail  = 0;

  pipe_stage_monitor #(.NSTAGE(4), .CNT_W(4)) dut (
    .CLK(CLK), .RSTN(RSTN), .stg_en(stg_en), .clr(clr),
    .busy(busy), .filling(filling), .running(running), .draining(draining),
    .fill_done(fill_done), .drain_done(drain_done), .run_cycles(run_cycles),
    .err(err), .err_code(err_code)
  );

  always #5 CLK = ~CLK;

  wire [12:0] st = {busy, filling, running, draining, fill_done, drain_done,
                    run_cycles, err, err_code};

  task automatic step(input logic [3:0] v, input logic c = 1'b0);
    stg_en = v;
    clr    = c;
    @(posedge CLK);
    #1;
  endtask

  task automatic expect_st(input string tag, input logic [3:0] ph, input logic fd,
                           input logic dd, input int rc, input logic e, input logic [1:0] ec);
    logic [12:0] exp_st;
    exp_st = {ph, fd, dd, 4'(rc), e, ec};
    n_tests++;
    assert (st === exp_st) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, st, exp_st);
    end
  endtask

  initial begin
    logic [1:0] ec_code, ec_step;
    ec_code = CHK ? 2'b01 : 2'b00;
    ec_step = CHK ? 2'b10 : 2'b00;

    // reset
    #3;
    expect_st("reset_async", IDLE, 0, 0, 0, 0, 2'b00);
    repeat (2) @(posedge CLK);
    #1;
    expect_st("reset_held", IDLE, 0, 0, 0, 0, 2'b00);
    #2 RSTN = 1'b1;
    repeat (3) step(4'h0);
    expect_st("idle_after_release", IDLE, 0, 0, 0, 0, 2'b00);

    // 1: legal cycle with two FULL samples
    step(4'h1); expect_st("t1_fill1", FILL, 0, 0, 0, 0, 2'b00);
    step(4'h3); expect_st("t1_fill2", FILL, 0, 0, 0, 0, 2'b00);
    step(4'h7); expect_st("t1_fill3", FILL, 0, 0, 0, 0, 2'b00);
    step(4'hF); expect_st("t1_full1", RUN, 1, 0, 1, 0, 2'b00);
    step(4'hF); expect_st("t1_full2", RUN, 0, 0, 2, 0, 2'b00);
    step(4'hE); expect_st("t1_drain3", DRAIN, 0, 0, 2, 0, 2'b00);
    step(4'hC); expect_st("t1_drain2", DRAIN, 0, 0, 2, 0, 2'b00);
    step(4'h8); expect_st("t1_drain1", DRAIN, 0, 0, 2, 0, 2'b00);
    step(4'h0); expect_st("t1_drain_done", IDLE, 0, 1, 2, 0, 2'b00);
    step(4'h0); expect_st("t1_idle_hold", IDLE, 0, 0, 2, 0, 2'b00);

    // 2: saturation of the 4-bit counter
    step(4'h1); expect_st("t2_new_run_clears", FILL, 0, 0, 0, 0, 2'b00);
    step(4'h3);
    step(4'h7);
    for (int i = 1; i <= 20; i++) begin
      step(4'hF);
      expect_st($sformatf("t2_full%0d", i), RUN, (i == 1), 0, (i > 15) ? 15 : i, 0, 2'b00);
    end
    step(4'hE);
    step(4'hC);
    step(4'h8);
    step(4'h0); expect_st("t2_drain_done_hold15", IDLE, 0, 1, 15, 0, 2'b00);

    // 3: illegal code
    step(4'h1); expect_st("t3_fill1", FILL, 0, 0, 0, 0, 2'b00);
    step(4'h3); expect_st("t3_fill2", FILL, 0, 0, 0, 0, 2'b00);
    step(4'h5); expect_st("t3_illegal_code", IDLE, 0, 0, 0, CHK, ec_code);
    step(4'h0); expect_st("t3_zero", IDLE, 0, 0, 0, CHK, ec_code);
    step(4'h1); expect_st("t3_refill", FILL, 0, 0, 0, CHK, ec_code);
    step(4'h3, 1'b1); expect_st("t3_clr", FILL, 0, 0, 0, 0, 2'b00);

    // 4: illegal step, later illegal code keeps the first cause
    step(4'h0); expect_st("t4_illegal_step", IDLE, 0, 0, 0, CHK, ec_step);
    step(4'h5); expect_st("t4_code_no_overwrite", IDLE, 0, 0, 0, CHK, ec_step);
    step(4'h0); expect_st("t4_sticky", IDLE, 0, 0, 0, CHK, ec_step);

    // 5: clr colliding with a new error, then clr alone
    step(4'h0, 1'b1); expect_st("t5_clr", IDLE, 0, 0, 0, 0, 2'b00);
    step(4'h1);
    step(4'h3);
    step(4'h7);
    step(4'hF); expect_st("t5_full", RUN, 1, 0, 1, 0, 2'b00);
    step(4'hC, 1'b1); expect_st("t5_clr_vs_err", DRAIN, 0, 0, 0, CHK, ec_step);
    step(4'h8, 1'b1); expect_st("t5_clr_alone", DRAIN, 0, 0, 0, 0, 2'b00);
    step(4'h0); expect_st("t5_drain_done", IDLE, 0, 1, 0, 0, 2'b00);

    // clr together with a FULL sample
    step(4'h1);
    step(4'h3);
    step(4'h7);
    step(4'hF); expect_st("clr_full_a", RUN, 1, 0, 1, 0, 2'b00);
    step(4'hF); expect_st("clr_full_b", RUN, 0, 0, 2, 0, 2'b00);
    step(4'hF, 1'b1); expect_st("clr_full_c", RUN, 0, 0, 1, 0, 2'b00);

    // 6: reset mid-run
    clr = 1'b0;
    #2 RSTN = 1'b0;
    #1 expect_st("t6_async_reset", IDLE, 0, 0, 0, 0, 2'b00);
    stg_en = 4'h0;
    @(posedge CLK);
    #2 RSTN = 1'b1;
    repeat (3) step(4'h0);
    expect_st("t6_released", IDLE, 0, 0, 0, 0, 2'b00);
    step(4'hF); expect_st("t6_zero_to_full", RUN, !CHK, 0, 1, CHK, ec_step);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // overall time bound
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, %0d tests run", n_tests);
    $fatal(1, "timeout");
  end

endmodule
